// File: rtl/dot_product_pkg.sv
// ---------------------------------------------------------------------------
// dot_product_pkg
//
// Purpose:
//   Shared number format, widths and helpers for the streaming
//   matrix-vector multiplier (dot_product) and its per-row lanes
//   (dot_product_mac).
//
//   Elements are signed fixed point Q(QN).(QM) with one sign bit, so
//   BITWIDTH = QN + QM + 1. A lane multiplies two elements into a
//   2*BITWIDTH product and sums up to 2^ADDR_BITWIDTH of them in an
//   accumulator that is ADDR_BITWIDTH bits wider than the product, so no
//   accumulation can overflow.
//
// Configuration macro:
//   SATURATE_EN - when defined, reduce_acc() clamps to the element range;
//                 when undefined, it keeps the low BITWIDTH bits (wrap).
// ---------------------------------------------------------------------------
package dot_product_pkg;

  localparam int QN            = 6;
  localparam int QM            = 11;
  localparam int BITWIDTH      = QN + QM + 1;
  localparam int ADDR_BITWIDTH = 4;
  localparam int PROD_WIDTH    = 2 * BITWIDTH;
  localparam int ACC_WIDTH     = PROD_WIDTH + ADDR_BITWIDTH;

  typedef logic signed [BITWIDTH-1:0]   elem_t;
  typedef logic signed [PROD_WIDTH-1:0] prod_t;
  typedef logic signed [ACC_WIDTH-1:0]  acc_t;

  // Pipeline tag that travels alongside the data of one column.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_tag_t;

  // Representable element range, expressed at accumulator width so the
  // clamp compares are plain signed compares.
  localparam acc_t OUT_MAX = acc_t'(2 ** (BITWIDTH - 1) - 1);
  localparam acc_t OUT_MIN = acc_t'(-(2 ** (BITWIDTH - 1)));

  // Reduce an already-rescaled accumulator value to one element.
  function automatic elem_t reduce_acc(input acc_t value);
`ifdef SATURATE_EN
    if (value > OUT_MAX) begin
      return elem_t'(OUT_MAX);
    end else if (value < OUT_MIN) begin
      return elem_t'(OUT_MIN);
    end else begin
      return elem_t'(value);
    end
`else
    return elem_t'(value);
`endif
  endfunction

endpackage

// File: rtl/dot_product_mac.sv
// ---------------------------------------------------------------------------
// dot_product_mac
//
// Purpose:
//   One row lane of the matrix-vector multiplier. Stage 1 registers the
//   full-precision signed product W[r][j] * x[j]. Stage 2 either starts a
//   new sum (first column), adds to the running sum, or, on the last
//   column, rescales (acc + product) by QM bits with floor rounding and
//   writes the reduced element to the result register.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   weight  in   BITWIDTH  W[r][j] for the column being sampled
//   x       in   BITWIDTH  x[j], aligned with weight
//   mul_en  in   1         weight/x are valid this cycle
//   tag     in   stage_tag_t  describes the product held in stage 1
//   result  out  BITWIDTH  y[r], held until the next completed pass
//
// Configuration macro:
//   SATURATE_EN - selects clamp vs. wrap in the final reduction.
// ---------------------------------------------------------------------------
module dot_product_mac
  import dot_product_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  elem_t      weight,
  input  elem_t      x,
  input  logic       mul_en,
  input  stage_tag_t tag,
  output elem_t      result
);

  prod_t mul_q;
  acc_t  acc_q;
  acc_t  acc_base;
  acc_t  sum;

  // The first column of a pass loads rather than adds, so a stale sum
  // from the previous pass never leaks in.
  always_comb begin
    acc_base = acc_q;
    if (tag.first) begin
      acc_base = '0;
    end
    sum = acc_base + acc_t'(mul_q);
  end

  // Stage 1 holds the product; stage 2 either accumulates or, on the
  // last column, bypasses the accumulator and writes the rescaled result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mul_q  <= '0;
      acc_q  <= '0;
      result <= '0;
    end else begin
      if (mul_en) begin
        mul_q <= prod_t'(weight) * prod_t'(x);
      end
      if (tag.valid) begin
        if (tag.last) begin
          result <= reduce_acc(sum >>> QM);
        end else begin
          acc_q <= sum;
        end
      end
    end
  end

endmodule

// File: rtl/dot_product.sv
// ---------------------------------------------------------------------------
// dot_product
//
// Purpose:
//   Streaming fixed-point matrix-vector multiplier y = W * x for the RNN
//   datapath. One weight column is read per cycle from an external
//   synchronous weight RAM (1-cycle read latency) while the host streams
//   the matching x element. The column counter runs continuously with no
//   bubble between passes; dataReady pulses once per completed product.
//
//   Timeline for column j (cycle 0 = first cycle out of reset):
//     cycle j     colAddress = j
//     cycle j+1   column j and x[j] present; product registered at end
//     cycle j+2   product accumulated (or final result written) at end
//   dataReady is therefore first high in cycle NCOL+2.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   weightMemOutput  in   BITWIDTH*NROW  column read last cycle,
//                                        row r at [r*BITWIDTH +: BITWIDTH]
//   inputVec         in   BITWIDTH       x[j], aligned with weight column j
//   dataReady        out  1              outputVec just updated
//   colAddress       out  ADDR_BITWIDTH  column index to the weight RAM
//   outputVec        out  BITWIDTH*NROW  y, row r at [r*BITWIDTH +: BITWIDTH]
//
// Configuration macro:
//   SATURATE_EN - final reduction clamps instead of wrapping (same latency).
// ---------------------------------------------------------------------------
module dot_product
  import dot_product_pkg::*;
#(
  parameter int NROW = 16,
  parameter int NCOL = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [BITWIDTH*NROW-1:0]   weightMemOutput,
  input  logic [BITWIDTH-1:0]        inputVec,
  output logic                       dataReady,
  output logic [ADDR_BITWIDTH-1:0]   colAddress,
  output logic [BITWIDTH*NROW-1:0]   outputVec
);

  localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

  stage_tag_t s0_tag;
  stage_tag_t s1_tag;

  // Column counter: runs every cycle and wraps straight back to zero so
  // consecutive passes are back to back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      colAddress <= '0;
    end else if (colAddress == LAST_COL) begin
      colAddress <= '0;
    end else begin
      colAddress <= colAddress + ADDR_BITWIDTH'(1);
    end
  end

  // The tags follow the RAM latency: s0 describes the column on
  // weightMemOutput this cycle, s1 the product held in the lanes. Both
  // start invalid so nothing is accumulated before real data arrives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s0_tag    <= '0;
      s1_tag    <= '0;
      dataReady <= 1'b0;
    end else begin
      s0_tag.valid <= 1'b1;
      s0_tag.first <= (colAddress == '0);
      s0_tag.last  <= (colAddress == LAST_COL);
      s1_tag       <= s0_tag;
      dataReady    <= s1_tag.valid & s1_tag.last;
    end
  end

  for (genvar r = 0; r < NROW; r++) begin : g_lane
    dot_product_mac u_mac (
      .clock  (clock),
      .reset  (reset),
      .weight (weightMemOutput[r*BITWIDTH +: BITWIDTH]),
      .x      (inputVec),
      .mul_en (s0_tag.valid),
      .tag    (s1_tag),
      .result (outputVec[r*BITWIDTH +: BITWIDTH])
    );
  end

endmodule

// File: tb/tb_dot_product.sv
// ---------------------------------------------------------------------------
// tb_dot_product
//
// Drives dot_product through a behavioural weight RAM and x stream, and
// compares colAddress, dataReady and outputVec against a plain-arithmetic
// model of y = W * x every cycle. A few literal row values per pattern pin
// the model itself.
//
// Configuration macro:
//   SATURATE_EN - must match the RTL build; selects the expected reduction.
// ---------------------------------------------------------------------------
module tb_dot_product;

  localparam int BW = 18;
  localparam int NR = 16;
  localparam int NC = 16;
  localparam int MW = BW * NR;
  localparam int FIRST_READY = NC + 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [MW-1:0] ram_q;
  logic [3:0]    ram_col_q;
  logic [BW-1:0] inputVec;
  logic          dataReady;
  logic [3:0]    colAddress;
  logic [MW-1:0] outputVec;

  int            w_val [NR][NC];
  int            x_val [NC];
  logic [MW-1:0] wmem [NC];
  logic [BW-1:0] x_bits [NC];
  logic [BW-1:0] lit_row0 = '0;
  logic [BW-1:0] lit_row15 = '0;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          exp_rdy;
  logic [MW-1:0] exp_out = '0;

  dot_product dut (
    .clock           (clock),
    .reset           (reset),
    .weightMemOutput (ram_q),
    .inputVec        (inputVec),
    .dataReady       (dataReady),
    .colAddress      (colAddress),
    .outputVec       (outputVec)
  );

  always #5 clock = ~clock;

  // Weight RAM: synchronous read, one cycle of latency, output register
  // cleared by reset. The host presents x for the column now on the bus.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_q     <= '0;
      ram_col_q <= '0;
    end else begin
      ram_q     <= wmem[colAddress];
      ram_col_q <= colAddress;
    end
  end

  assign inputVec = x_bits[ram_col_q];

  // y[r] = floor(sum_j W[r][j]*x[j] / 2^11), then clamp or wrap to 18 bits.
  function automatic logic [MW-1:0] model_vec();
    logic [MW-1:0] v;
    longint        acc;
    v = '0;
    for (int r = 0; r < NR; r++) begin
      acc = 0;
      for (int j = 0; j < NC; j++) begin
        acc += longint'(w_val[r][j]) * longint'(x_val[j]);
      end
      acc = acc >>> 11;
`ifdef SATURATE_EN
      if (acc > 131071) acc = 131071;
      else if (acc < -131072) acc = -131072;
`endif
      v[r*BW +: BW] = acc[BW-1:0];
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [MW-1:0] got,
                             input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Every negedge: in reset everything must be zero; otherwise the column
  // counter, the pulse schedule and the held result follow the model.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_out = '0;
        checkOutput("reset colAddress", MW'(colAddress), '0);
        checkOutput("reset dataReady", MW'(dataReady), '0);
        checkOutput("reset outputVec", outputVec, '0);
        cyc = 0;
      end else begin
        exp_rdy = (cyc >= FIRST_READY) && (((cyc - FIRST_READY) % NC) == 0);
        if (exp_rdy) exp_out = model_vec();
        checkOutput("colAddress", MW'(colAddress), MW'(cyc % NC));
        checkOutput("dataReady", MW'(dataReady), MW'(exp_rdy));
        checkOutput("outputVec", outputVec, exp_out);
        if (cyc == FIRST_READY) begin
          checkOutput("model row0 literal", MW'(exp_out[BW-1:0]), MW'(lit_row0));
          checkOutput("dut row0 literal", MW'(outputVec[BW-1:0]), MW'(lit_row0));
          checkOutput("dut row15 literal", MW'(outputVec[MW-1 -: BW]), MW'(lit_row15));
        end
        cyc++;
      end
    end
  end

  // Load a pattern while reset is low (2 cycles), then release so the next
  // cycle is cycle 0.
  task automatic applyStimulus(input int pattern);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        case (pattern)
          1:       w_val[r][c] = (r == c) ? 2048 : 0;
          default: w_val[r][c] = 2048;
        endcase
      end
    end
    for (int j = 0; j < NC; j++) begin
      case (pattern)
        0:       x_val[j] = 1;
        1:       x_val[j] = (j + 1) * 2048;
        2:       x_val[j] = -2048;
        default: x_val[j] = 16384;
      endcase
    end
    case (pattern)
      0: begin lit_row0 = 18'd16; lit_row15 = 18'd16; end
      1: begin lit_row0 = 18'd2048; lit_row15 = 18'd32768; end
      2: begin lit_row0 = 18'h38000; lit_row15 = 18'h38000; end
      default: begin
`ifdef SATURATE_EN
        lit_row0 = 18'd131071; lit_row15 = 18'd131071;
`else
        lit_row0 = 18'd0; lit_row15 = 18'd0;
`endif
      end
    endcase
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        wmem[c][r*BW +: BW] = BW'(w_val[r][c]);
      end
      x_bits[c] = BW'(x_val[c]);
    end
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge clock);
  endtask

  // Called right after an active edge: holds reset low for one full cycle.
  task automatic pulseReset();
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    $display("[TB] all-ones pattern, three passes");
    applyStimulus(0);
    runCycles(52);
    $display("[TB] identity pattern");
    applyStimulus(1);
    runCycles(20);
    $display("[TB] negative pattern");
    applyStimulus(2);
    runCycles(20);
    $display("[TB] overflow pattern");
    applyStimulus(3);
    runCycles(20);
    $display("[TB] mid-pass resets");
    applyStimulus(1);
    runCycles(9);
    pulseReset();
    runCycles(25);
    pulseReset();
    runCycles(20);
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
